// File: rtl/map_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : map_port_arbiter
// Purpose  : Round-robin owner of map RAM port B. Serialises single-cell
//            read-modify-write updates and returns each cell's previous code.
// Options  : MAP_ARB_STATS_EN adds grant_cnt / err_cnt statistics outputs.
// Revision : 1.0
// ============================================================================
module map_port_arbiter #(
  parameter int ROWS   = 30,
  parameter int COLS   = 40,
  parameter int RD_LAT = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [2:0]          req,
  input  logic [14:0]         req_row,
  input  logic [17:0]         req_col,
  input  logic [11:0]         req_code,
  output logic [2:0]          done,
  output logic                err,
  output logic [3:0]          old_code,
  output logic                busy,
  output logic [4:0]          wraddr,
  output logic [4*COLS-1:0]   wrdata,
  output logic                wren,
  input  logic [4*COLS-1:0]   redata
`ifdef MAP_ARB_STATS_EN
  ,
  output logic [47:0]         grant_cnt,
  output logic [7:0]          err_cnt
`endif
);

  localparam int c_ROW_W  = 4 * COLS;
  localparam int c_LSB_W  = $clog2(c_ROW_W);
  localparam int c_WAIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_gnt;
  logic [4:0]          r_row;
  logic [5:0]          r_col;
  logic [3:0]          r_code;
  logic [3:0]          r_old;
  logic [c_WAIT_W-1:0] r_wait;

  logic                w_any;
  logic [1:0]          w_gnt;
  logic [1:0]          w_next;
  logic [2:0]          w_idx;
  logic [4:0]          w_row;
  logic [5:0]          w_col;
  logic [3:0]          w_code;
  logic                w_range_err;
  logic [c_LSB_W-1:0]  w_lsb;
  logic [c_ROW_W-1:0]  w_merged;
  logic [3:0]          w_old;

  // Scan from the highest offset down so the requester nearest r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = 2'd0;
    w_idx = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + 3'(k);
      if (w_idx >= 3'd3) w_idx = w_idx - 3'd3;
      if (req[w_idx[1:0]]) begin
        w_any = 1'b1;
        w_gnt = w_idx[1:0];
      end
    end
    w_next = (w_gnt == 2'd2) ? 2'd0 : w_gnt + 2'd1;
  end

  always_comb begin
    case (w_gnt)
      2'd1:    begin w_row = req_row[9:5];   w_col = req_col[11:6];  w_code = req_code[7:4];  end
      2'd2:    begin w_row = req_row[14:10]; w_col = req_col[17:12]; w_code = req_code[11:8]; end
      default: begin w_row = req_row[4:0];   w_col = req_col[5:0];   w_code = req_code[3:0];  end
    endcase
  end

  // Column 0 lives in the top nibble of the row word.
  always_comb begin
    w_range_err = (int'(r_row) >= ROWS) || (int'(r_col) >= COLS);
    w_lsb       = c_LSB_W'(c_ROW_W - 4) - c_LSB_W'({r_col, 2'b00});
    w_merged    = redata;
    w_merged[w_lsb +: 4] = r_code;
    w_old       = redata[w_lsb +: 4];
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= 2'd0;
      r_gnt    <= 2'd0;
      r_row    <= '0;
      r_col    <= '0;
      r_code   <= '0;
      r_old    <= '0;
      r_wait   <= '0;
      done     <= '0;
      err      <= 1'b0;
      old_code <= '0;
      busy     <= 1'b0;
      wraddr   <= '0;
      wrdata   <= '0;
      wren     <= 1'b0;
    end else begin
      done <= '0;
      wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_row   <= w_row;
            r_col   <= w_col;
            r_code  <= w_code;
            r_ptr   <= w_next;
            busy    <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_range_err) begin
            done     <= 3'b001 << r_gnt;
            err      <= 1'b1;
            old_code <= 4'd0;
            r_state  <= S_DONE;
          end else begin
            wraddr  <= r_row;
            r_wait  <= '0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (r_wait == c_WAIT_W'(RD_LAT - 1)) begin
            wrdata  <= w_merged;
            r_old   <= w_old;
            wren    <= 1'b1;
            r_state <= S_WRITE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WRITE: begin
          done     <= 3'b001 << r_gnt;
          err      <= 1'b0;
          old_code <= r_old;
          r_state  <= S_DONE;
        end
        default: begin
          err      <= 1'b0;
          old_code <= 4'd0;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MAP_ARB_STATS_EN
  for (genvar gi = 0; gi < 3; gi++) begin : g_grant_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n)
        r_cnt <= '0;
      else if (done[gi] && !err && r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
    end
    assign grant_cnt[16*gi +: 16] = r_cnt;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)
      err_cnt <= '0;
    else if ((|done) && err && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_map_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_port_arbiter
// Purpose  : Directed scoreboard bench for map_port_arbiter with a port-B RAM
//            model (2-cycle read latency). MAP_ARB_STATS_EN checks counters.
// Revision : 1.0
// ============================================================================
module tb_map_port_arbiter;

  logic         CLOCK_50 = 1'b0;
  logic         reset_n;
  logic [2:0]   req;
  logic [14:0]  req_row;
  logic [17:0]  req_col;
  logic [11:0]  req_code;
  logic [2:0]   done;
  logic         err;
  logic [3:0]   old_code;
  logic         busy;
  logic [4:0]   wraddr;
  logic [159:0] wrdata;
  logic         wren;
  logic [159:0] redata;
`ifdef MAP_ARB_STATS_EN
  logic [47:0]  grant_cnt;
  logic [7:0]   err_cnt;
`endif

  map_port_arbiter #(.ROWS(30), .COLS(40), .RD_LAT(2)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .req      (req),
    .req_row  (req_row),
    .req_col  (req_col),
    .req_code (req_code),
    .done     (done),
    .err      (err),
    .old_code (old_code),
    .busy     (busy),
    .wraddr   (wraddr),
    .wrdata   (wrdata),
    .wren     (wren),
    .redata   (redata)
`ifdef MAP_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // RAM model: registered address, so data for wraddr appears one cycle later.
  logic [159:0] mem [32];
  logic         mem_ok = 1'b0;
  logic [4:0]   addr_d = 5'd0;

  function automatic logic [159:0] pat(input int r);
    logic [4:0] rr;
    rr = 5'(r);
    if (r == 5) return {40{4'h1}};
    return {40{rr[3:0]}};
  endfunction

  always @(posedge CLOCK_50) begin
    addr_d <= wraddr;
    if (!mem_ok) begin
      for (int r = 0; r < 32; r++) mem[r] <= pat(r);
      mem_ok <= 1'b1;
    end else if (wren) begin
      mem[wraddr] <= wrdata;
    end
  end
  assign redata = mem[addr_d];

  typedef struct { logic [2:0] dv; logic er; logic [3:0] old; } dexp_t;
  typedef struct { logic [4:0] addr; logic [159:0] data; } wexp_t;
  dexp_t sq[$];
  wexp_t wq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int wren_seen = 0;
  int last_wren_cyc = 0;
  int t_req = 0;

  function automatic void check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void push_done(input int i, input logic e, input logic [3:0] o);
    dexp_t d;
    d.dv  = 3'b001 << i;
    d.er  = e;
    d.old = o;
    sq.push_back(d);
  endfunction

  function automatic void push_wr(input logic [4:0] a, input logic [159:0] dat);
    wexp_t w;
    w.addr = a;
    w.data = dat;
    wq.push_back(w);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT writes or pulses done.
  initial begin
    dexp_t de;
    wexp_t we;
    forever begin
      @(negedge CLOCK_50);
      if (reset_n && wren) begin
        wren_seen++;
        last_wren_cyc = cyc;
        if (wq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_wren: addr %0d written, no write expected", wraddr);
        end else begin
          we = wq.pop_front();
          check("wraddr", 160'(wraddr), 160'(we.addr));
          check("wrdata", wrdata, we.data);
        end
      end
      if (reset_n && done != 3'b000) begin
        if (sq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: done=%b, no completion expected", done);
        end else begin
          de = sq.pop_front();
          check("done_vec", 160'(done), 160'(de.dv));
          check("err", 160'(err), 160'(de.er));
          check("old_code", 160'(old_code), 160'(de.old));
        end
      end
    end
  end

  task automatic run_req(input int i, input int row, input int col, input int code, output int lat);
    bit got;
    req_row[5*i +: 5]  = 5'(row);
    req_col[6*i +: 6]  = 6'(col);
    req_code[4*i +: 4] = 4'(code);
    req[i] = 1'b1;
    t_req  = cyc;
    got    = 1'b0;
    lat    = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge CLOCK_50);
      if (done[i]) begin
        got = 1'b1;
        lat = cyc - t_req;
      end
    end
    req[i] = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_req%0d: no done within 60 cycles, expected a done pulse", i);
    end
  endtask

  initial begin
    int lat, l0, l1, l2;
    int w_before;
    reset_n = 1'b0; req = '0; req_row = '0; req_col = '0; req_code = '0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_done",     160'(done),     160'(0));
    check("rst_err",      160'(err),      160'(0));
    check("rst_old_code", 160'(old_code), 160'(0));
    check("rst_busy",     160'(busy),     160'(0));
    check("rst_wren",     160'(wren),     160'(0));
    check("rst_wraddr",   160'(wraddr),   160'(0));
    check("rst_wrdata",   wrdata,         160'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Single write with latency check.
    push_wr(5'd5, {4'h3, {39{4'h1}}});
    push_done(0, 1'b0, 4'h1);
    run_req(0, 5, 0, 3, lat);
    check("done_latency", 160'(lat), 160'(5));
    check("wren_latency", 160'(last_wren_cyc - t_req), 160'(4));
    @(negedge CLOCK_50);

    // Last column: only the bottom nibble changes.
    push_wr(5'd29, {{39{4'hD}}, 4'hA});
    push_done(1, 1'b0, 4'hD);
    run_req(1, 29, 39, 10, lat);
    @(negedge CLOCK_50);

    // Out of range row and column: err, no write.
    push_done(2, 1'b1, 4'h0);
    run_req(2, 30, 0, 5, lat);
    @(negedge CLOCK_50);
    push_done(2, 1'b1, 4'h0);
    run_req(2, 0, 40, 5, lat);
    @(negedge CLOCK_50);

    // Same code as already stored still writes.
    push_wr(5'd5, {4'h3, {39{4'h1}}});
    push_done(1, 1'b0, 4'h3);
    run_req(1, 5, 0, 3, lat);
    @(negedge CLOCK_50);

    // Contention from reset release: order 0,1,2 then the re-raised 0.
    reset_n = 1'b0;
    push_wr(5'd10, {4'hA, 4'h0, {38{4'hA}}});       push_done(0, 1'b0, 4'hA);
    push_wr(5'd11, {{2{4'hB}}, 4'h5, {37{4'hB}}});  push_done(1, 1'b0, 4'hB);
    push_wr(5'd12, {{38{4'hC}}, 4'h7, 4'hC});       push_done(2, 1'b0, 4'hC);
    push_wr(5'd13, {{20{4'hD}}, 4'h1, {19{4'hD}}}); push_done(0, 1'b0, 4'hD);
    fork
      begin
        run_req(0, 10, 1, 0, l0);
        @(negedge CLOCK_50);
        run_req(0, 13, 20, 1, l0);
      end
      run_req(1, 11, 2, 5, l1);
      run_req(2, 12, 38, 7, l2);
      begin
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
      end
    join
    @(negedge CLOCK_50);

    // Reset in the middle of READ aborts without a write or done.
    w_before = wren_seen;
    req_row[4:0] = 5'd3; req_col[5:0] = 6'd2; req_code[3:0] = 4'h9;
    req[0] = 1'b1;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #2;
    check("busy_inflight", 160'(busy), 160'(1));
    reset_n = 1'b0;
    #1;
    check("abort_wren", 160'(wren), 160'(0));
    check("abort_busy", 160'(busy), 160'(0));
    check("abort_done", 160'(done), 160'(0));
    req[0] = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("abort_row3_intact", mem[3], {40{4'h3}});
    check("abort_no_wren", 160'(wren_seen), 160'(w_before));

`ifdef MAP_ARB_STATS_EN
    reset_n = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    push_wr(5'd7, {4'h5, {39{4'h7}}});                push_done(1, 1'b0, 4'h7);
    run_req(1, 7, 0, 5, lat);
    @(negedge CLOCK_50);
    push_wr(5'd7, {{2{4'h5}}, {38{4'h7}}});           push_done(1, 1'b0, 4'h7);
    run_req(1, 7, 1, 5, lat);
    @(negedge CLOCK_50);
    push_wr(5'd7, {{3{4'h5}}, {37{4'h7}}});           push_done(1, 1'b0, 4'h7);
    run_req(1, 7, 2, 5, lat);
    @(negedge CLOCK_50);
    push_done(1, 1'b1, 4'h0);
    run_req(1, 31, 0, 0, lat);
    repeat (2) @(negedge CLOCK_50);
    check("grant_cnt_r1", 160'(grant_cnt[31:16]), 160'(3));
    check("grant_cnt_r0", 160'(grant_cnt[15:0]),  160'(0));
    check("err_cnt",      160'(err_cnt),          160'(1));
`endif

    repeat (3) @(negedge CLOCK_50);
    check("done_queue_drained",  160'(sq.size()), 160'(0));
    check("write_queue_drained", 160'(wq.size()), 160'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/map_port_arbiter.md
Name: map_port_arbiter

Overview:
- Owns write port B of the 30x160-bit map RAM and shares it between three requesters: 0 = pacman mover, 1 = ghost mover, 2 = map restore/pill refill.
- Each requester asks for a single-cell update: row, column and a 4-bit object code.
- The arbiter performs a read-modify-write on the 160-bit row and returns the cell's previous code, which is used for collision typing.
- It sits between the sprite controllers and the RAM, replacing direct, uncoordinated port-B drive.

Parameters:
- ROWS, 30, number of map rows; valid row is 0..ROWS-1.
- COLS, 40, cells per row; valid column is 0..COLS-1; row width = 4*COLS = 160.
- RD_LAT, 2, RAM port-B read latency in cycles, from wraddr stable to redata valid (range 1..4).

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  3  per-requester request; must be held until that requester's done.
- req_row  in  15  packed 3x5-bit row; requester i uses bits [5i+:5].
- req_col  in  18  packed 3x6-bit column; requester i uses bits [6i+:6].
- req_code  in  12  packed 3x4-bit new cell code; requester i uses bits [4i+:4].
- done  out  3  one-cycle pulse to the served requester.
- err  out  1  valid with done; request was out of range and no write occurred.
- old_code  out  4  previous cell code, valid with done; 0 when err is set.
- busy  out  1  high whenever state is not IDLE.
- wraddr  out  5  RAM port-B address.
- wrdata  out  160  RAM port-B write data.
- wren  out  1  RAM port-B write enable.
- redata  in  160  RAM port-B read data.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; done=0, err=0, old_code=0, busy=0, wren=0, wraddr=0, wrdata=0.
  - Round-robin pointer is set to requester 0 as highest priority.
  - Reset mid-transaction aborts the transaction; wren drops immediately (no partial write) and no done is issued.
- Cell mapping: column c occupies row bits [156-4c +: 4], so column 0 is bits 159:156 and column 39 is bits 3:0.
- States and transitions:
  - IDLE:
    - If any req is set, grant the highest-priority requester in round-robin order starting at pointer.
    - Latch its row, col and code, and the granted index g; go to CHECK.
    - The pointer becomes (g+1) mod 3.
    - If no req is set, stay in IDLE.
  - CHECK:
    - If row>=ROWS or col>=COLS, go to DONE with err=1.
    - Otherwise drive wraddr=row, reset the wait counter, and go to READ.
  - READ:
    - Hold wraddr; count RD_LAT cycles.
    - On the final cycle, capture redata into the row buffer and the old cell nibble; go to WRITE.
  - WRITE (exactly 1 cycle):
    - wren=1, wraddr=row, wrdata=row buffer with the target nibble replaced by code; go to DONE.
  - DONE (1 cycle):
    - done[g]=1, with err and old_code valid; return to IDLE.
- Timing:
  - Grant at edge T means wren is high during cycle T+RD_LAT+2 and done is high during cycle T+RD_LAT+3.
  - Total service time is RD_LAT+4 cycles, including the IDLE cycle.
- Handshake:
  - Dropping req before done does not cancel an in-flight transaction; done is still pulsed.
  - The requester must clear req in the cycle after done. A req still high at the next IDLE sample is treated as a new request.
- Simultaneous requests are served one at a time in round-robin order; no request is lost while it stays asserted.
- Worst-case wait before grant is two other transactions.
- Requests arriving while busy are sampled only in IDLE.
- wren is never high outside WRITE. wrdata bits outside the target nibble equal the redata captured in READ.
- Writing code equal to old_code still performs the write.

Optional Feature:
- Macro: MAP_ARB_STATS_EN.
- When defined, the block adds:
  - Output grant_cnt (48 bits, 3x16): per-requester count of completed non-err transactions, saturating at 16'hFFFF.
  - Output err_cnt (8 bits): count of err completions, saturating at 8'hFF.
  - Both are cleared by reset_n.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single write: req[0] with row=5, col=0, code=4'h3, redata row 5 = all 4'h1 nibbles → wren for 1 cycle at T+4 (RD_LAT=2), wraddr=5, wrdata[159:156]=3 with all other nibbles 1; done[0] at T+5, old_code=1, err=0.
- Column 39 edge: req[1] with row=29, col=39, code=4'hA → only wrdata[3:0]=A changes; done[1] pulses.
- Out of range: req[2] with row=30 or col=40 → wren stays 0 throughout, done[2] with err=1 and old_code=0.
- Contention: all three req high from reset release → grants in order 0, 1, 2; with req[0] re-raised after its done, next order is 0 only after 1 and 2 are served; three non-overlapping wren pulses.
- Reset mid-op: assert reset_n=0 during READ → wren=0, busy=0, done=0 immediately; no RAM write occurs after reset_n is released.
- MAP_ARB_STATS_EN: 3 good transactions by requester 1 and 1 err → grant_cnt[31:16]=3, err_cnt=1.
